// File: rtl/row_accum_lif.sv
// row_accum_lif: sums ROWS partial-sum packets per lane, integrates the result into
// persistent per-lane membrane potentials and emits one spike/result packet per timestep.
module row_accum_lif #(
    parameter int               LANES      = 3,
    parameter int               DATA_W     = 8,
    parameter int               SPK_W      = 5,
    parameter int               ROWS       = 3,
    parameter int               MEM_W      = 12,
    parameter logic [MEM_W-1:0] THRESH     = MEM_W'(24),
    parameter int               RESET_MODE = 0,
    parameter int               T_STEPS    = 4,
    parameter logic [3:0]       OWN_ADDR   = 4'd0,
    parameter logic [3:0]       OUT_DST    = 4'd1,
    parameter logic [1:0]       PSUM_TYPE  = 2'b01,
    localparam int              PKT_W      = 10 + SPK_W + LANES * DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PKT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             drop,
    output logic             ts_done
);

    localparam int SUM_W    = DATA_W + $clog2(ROWS);
    localparam int ADD_W    = ((MEM_W > SUM_W) ? MEM_W : SUM_W) + 1;
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS + 1) : 1;
    localparam int TS_W     = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
    localparam int DATA_MAX = (1 << DATA_W) - 1;
    localparam logic [MEM_W-1:0] MEM_MAX = {MEM_W{1'b1}};

    typedef enum logic [1:0] {ACCUM, FIRE, SEND} state_t;

    state_t             state, next_state;
    logic [SUM_W-1:0]   sum [LANES];
    logic [MEM_W-1:0]   mem [LANES];
    logic [ROW_W-1:0]   row_cnt;
    logic [TS_W-1:0]    ts_cnt;

    logic               take, type_ok, last_row, last_ts;
    logic [ADD_W-1:0]   total    [LANES];
    logic [MEM_W-1:0]   pot      [LANES];
    logic [MEM_W-1:0]   mem_fire [LANES];
    logic [DATA_W-1:0]  lane_out [LANES];
    logic [SPK_W-1:0]   spikes;
    logic [PKT_W-1:0]   fire_pkt;

    // Header fields other than the type are not needed on the input side.
    logic unused_fields;
    assign unused_fields = ^in_data[PKT_W-3 -: 8 + SPK_W];

    assign take     = in_valid && in_ready;
    assign type_ok  = (in_data[PKT_W-1 -: 2] == PSUM_TYPE);
    assign last_row = (row_cnt == ROW_W'(ROWS - 1));
    assign last_ts  = (ts_cnt == TS_W'(T_STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= next_state;
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (take && type_ok && last_row) next_state = FIRE;
            FIRE:    next_state = SEND;
            SEND:    if (out_ready) next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // Integrate, saturate, threshold and build the outgoing packet for the FIRE cycle.
    always_comb begin
        spikes   = '0;
        fire_pkt = '0;
        for (int i = 0; i < LANES; i++) begin
            total[i]    = ADD_W'(mem[i]) + ADD_W'(sum[i]);
            pot[i]      = (total[i] > ADD_W'(MEM_MAX)) ? MEM_MAX : total[i][MEM_W-1:0];
            spikes[LANES-1-i] = (pot[i] >= THRESH);
            if (pot[i] >= THRESH)
                mem_fire[i] = (RESET_MODE != 0) ? pot[i] - THRESH : '0;
            else
                mem_fire[i] = pot[i];
            lane_out[i] = (pot[i] > MEM_W'(DATA_MAX)) ? DATA_W'(DATA_MAX) : DATA_W'(pot[i]);
            fire_pkt[(LANES-1-i)*DATA_W +: DATA_W] = lane_out[i];
        end
        fire_pkt[PKT_W-1 -: 2]     = PSUM_TYPE;
        fire_pkt[PKT_W-3 -: 4]     = OUT_DST;
        fire_pkt[PKT_W-7 -: 4]     = OWN_ADDR;
        fire_pkt[PKT_W-11 -: SPK_W] = spikes;
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            drop      <= 1'b0;
            ts_done   <= 1'b0;
            row_cnt   <= '0;
            ts_cnt    <= '0;
            // NOTE: potentials are architectural state and must start at zero, so the arrays are reset.
            for (int i = 0; i < LANES; i++) begin
                sum[i] <= '0;
                mem[i] <= '0;
            end
        end else begin
            in_ready  <= (next_state == ACCUM);
            out_valid <= (next_state == SEND);
            drop      <= take && !type_ok;
            ts_done   <= 1'b0;
            case (state)
                ACCUM: begin
                    if (take && type_ok) begin
                        for (int i = 0; i < LANES; i++)
                            sum[i] <= sum[i] + SUM_W'(in_data[(LANES-1-i)*DATA_W +: DATA_W]);
                        row_cnt <= row_cnt + ROW_W'(1);
                    end
                end
                FIRE: begin
                    out_data <= fire_pkt;
                    row_cnt  <= '0;
                    for (int i = 0; i < LANES; i++) begin
                        mem[i] <= mem_fire[i];
                        sum[i] <= '0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (last_ts) begin
                            ts_cnt  <= '0;
                            ts_done <= 1'b1;
                            for (int i = 0; i < LANES; i++) mem[i] <= '0;
                        end else begin
                            ts_cnt <= ts_cnt + TS_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_row_accum_lif.sv
// Directed bench for row_accum_lif: three instances cover reset-to-zero, subtract-reset
// and saturation configurations with hand-computed expected packets.
module tb_row_accum_lif;

    localparam int PW = 39;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] in_data   [3];
    logic          in_valid  [3];
    logic          out_ready [3];
    logic          in_ready  [3];
    logic          out_valid [3];
    logic          drop      [3];
    logic          ts_done   [3];
    logic [PW-1:0] out_data  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    row_accum_lif dut0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .drop(drop[0]), .ts_done(ts_done[0]));

    row_accum_lif #(.RESET_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .drop(drop[1]), .ts_done(ts_done[1]));

    row_accum_lif #(.THRESH(12'd4095), .T_STEPS(16)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .drop(drop[2]), .ts_done(ts_done[2]));

    function automatic logic [PW-1:0] in_pkt(input logic [1:0] t, input logic [7:0] a, b, c);
        return {t, 4'd0, 4'd3, 5'd0, a, b, c};
    endfunction

    function automatic logic [PW-1:0] exp_pkt(input logic [4:0] s, input logic [7:0] a, b, c);
        return {2'b01, 4'd1, 4'd0, s, a, b, c};
    endfunction

    task automatic send(input int d, input logic [PW-1:0] p);
        bit ok;
        ok = 1'b0;
        in_data[d]  = p;
        in_valid[d] = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            ok = in_ready[d];
            @(posedge clk); #1;
        end
        in_valid[d] = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout dut%0d: in_ready never high, required 1", d);
        end
    endtask

    task automatic wait_out(input int d);
        for (int n = 0; n < 20 && out_valid[d] !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        if (out_valid[d] !== 1'b1) begin
            checks++; errors++;
            $display("FAIL out_timeout dut%0d: out_valid=%b required 1", d, out_valid[d]);
        end
    endtask

    task automatic accept(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic send_std(input int d);
        send(d, in_pkt(2'b01, 8'd14, 8'd5, 8'd8));
        send(d, in_pkt(2'b01, 8'd4, 8'd8, 8'd7));
        send(d, in_pkt(2'b01, 8'd10, 8'd9, 8'd10));
    endtask

    task automatic run_std(input int d, output logic [PW-1:0] got);
        send_std(d);
        wait_out(d);
        got = out_data[d];
        accept(d);
    endtask

    task automatic run_same(input int d, input logic [7:0] a, b, c, output logic [PW-1:0] got);
        for (int r = 0; r < 3; r++) send(d, in_pkt(2'b01, a, b, c));
        wait_out(d);
        got = out_data[d];
        accept(d);
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++;
        if ({in_ready[0], out_valid[0], drop[0], ts_done[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/valid/drop/done=%b required 0000",
                     {in_ready[0], out_valid[0], drop[0], ts_done[0]});
        end
        checks++;
        if (out_data[0] !== '0) begin
            errors++; $display("FAIL reset_data: got %h required 0", out_data[0]);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", in_ready[0]);
        end
    endtask

    task automatic test_latency;
        send(0, in_pkt(2'b01, 8'd14, 8'd5, 8'd8));
        send(0, in_pkt(2'b01, 8'd4, 8'd8, 8'd7));
        send(0, in_pkt(2'b01, 8'd10, 8'd9, 8'd10));
        checks++;
        if ({out_valid[0], in_ready[0]} !== 2'b00) begin
            errors++; $display("FAIL fire_cycle: valid/ready=%b required 00", {out_valid[0], in_ready[0]});
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid[0], in_ready[0]} !== 2'b10) begin
            errors++; $display("FAIL send_cycle: valid/ready=%b required 10", {out_valid[0], in_ready[0]});
        end
        checks++;
        if (out_data[0] !== exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25)) begin
            errors++; $display("FAIL step1_data: got %h required %h", out_data[0],
                               exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25));
        end
        accept(0);
        checks++;
        if ({out_valid[0], in_ready[0], ts_done[0]} !== 3'b010) begin
            errors++; $display("FAIL after_accept: valid/ready/done=%b required 010",
                               {out_valid[0], in_ready[0], ts_done[0]});
        end
    endtask

    task automatic test_accumulate;
        logic [PW-1:0] got;
        run_std(0, got);
        checks++;
        if (got !== exp_pkt(5'b00111, 8'd28, 8'd44, 8'd25)) begin
            errors++; $display("FAIL step2_data: got %h required %h", got, exp_pkt(5'b00111, 8'd28, 8'd44, 8'd25));
        end
    endtask

    task automatic test_drop;
        send(0, in_pkt(2'b01, 8'd14, 8'd5, 8'd8));
        send(0, in_pkt(2'b10, 8'd200, 8'd200, 8'd200));
        checks++;
        if (drop[0] !== 1'b1) begin
            errors++; $display("FAIL drop_pulse: got %b required 1", drop[0]);
        end
        send(0, in_pkt(2'b01, 8'd4, 8'd8, 8'd7));
        checks++;
        if ({drop[0], in_ready[0]} !== 2'b01) begin
            errors++; $display("FAIL drop_rowcnt: drop/ready=%b required 01", {drop[0], in_ready[0]});
        end
        send(0, in_pkt(2'b01, 8'd10, 8'd9, 8'd10));
        wait_out(0);
        checks++;
        if (out_data[0] !== exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25)) begin
            errors++; $display("FAIL drop_data: got %h required %h", out_data[0],
                               exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25));
        end
        accept(0);
    endtask

    task automatic test_backpressure;
        int bad;
        bad = 0;
        for (int r = 0; r < 3; r++) send(0, in_pkt(2'b01, 8'd1, 8'd1, 8'd1));
        wait_out(0);
        in_data[0]  = in_pkt(2'b01, 8'd14, 8'd5, 8'd8);
        in_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_data[0] !== exp_pkt(5'b00010, 8'd3, 8'd25, 8'd3) || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                errors++; bad++;
                $display("FAIL hold_cycle%0d: data=%h valid=%b ready=%b required %h 1 0", c, out_data[0],
                         out_valid[0], in_ready[0], exp_pkt(5'b00010, 8'd3, 8'd25, 8'd3));
            end
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        checks++;
        if ({ts_done[0], out_valid[0], in_ready[0]} !== 3'b101) begin
            errors++; $display("FAIL ts_done_pulse: done/valid/ready=%b required 101",
                               {ts_done[0], out_valid[0], in_ready[0]});
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        checks++;
        if (ts_done[0] !== 1'b0) begin
            errors++; $display("FAIL ts_done_width: got %b required 0", ts_done[0]);
        end
        send(0, in_pkt(2'b01, 8'd4, 8'd8, 8'd7));
        send(0, in_pkt(2'b01, 8'd10, 8'd9, 8'd10));
        wait_out(0);
        checks++;
        if (out_data[0] !== exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25)) begin
            errors++; $display("FAIL pending_consumed: got %h required %h", out_data[0],
                               exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25));
        end
        accept(0);
    endtask

    task automatic test_reset_mode;
        logic [PW-1:0] got;
        run_std(1, got);
        checks++;
        if (got !== exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25)) begin
            errors++; $display("FAIL sub_step1: got %h required %h", got, exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25));
        end
        run_std(1, got);
        checks++;
        if (got !== exp_pkt(5'b00111, 8'd32, 8'd44, 8'd26)) begin
            errors++; $display("FAIL sub_step2: got %h required %h", got, exp_pkt(5'b00111, 8'd32, 8'd44, 8'd26));
        end
    endtask

    task automatic test_saturation;
        logic [PW-1:0] got;
        logic [4:0]    spk;
        for (int k = 1; k <= 7; k++) begin
            run_same(2, 8'd255, 8'd255, 8'd255, got);
            spk = (k == 6) ? 5'b00111 : 5'b00000;
            checks++;
            if (got !== exp_pkt(spk, 8'd255, 8'd255, 8'd255)) begin
                errors++; $display("FAIL sat_step%0d: got %h required %h", k, got,
                                   exp_pkt(spk, 8'd255, 8'd255, 8'd255));
            end
        end
    endtask

    task automatic test_rst_mid;
        logic [PW-1:0] got;
        send(0, in_pkt(2'b01, 8'd14, 8'd5, 8'd8));
        send(0, in_pkt(2'b01, 8'd4, 8'd8, 8'd7));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({out_valid[0], in_ready[0]} !== 2'b00) begin
            errors++; $display("FAIL rst_partial: valid/ready=%b required 00", {out_valid[0], in_ready[0]});
        end
        send_std(0);
        wait_out(0);
        checks++;
        if (out_data[0] !== exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25)) begin
            errors++; $display("FAIL rst_partial_data: got %h required %h", out_data[0],
                               exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== '0) begin
            errors++; $display("FAIL rst_send: valid=%b data=%h required 0 0", out_valid[0], out_data[0]);
        end
        run_std(0, got);
        checks++;
        if (got !== exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25)) begin
            errors++; $display("FAIL rst_send_data: got %h required %h", got, exp_pkt(5'b00101, 8'd28, 8'd22, 8'd25));
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_data[d]   = '0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        test_reset;
        test_latency;
        test_accumulate;
        test_drop;
        test_backpressure;
        test_reset_mode;
        test_saturation;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
